// File: rtl/tm_sr_rx_mon_if.sv
// SR/TM receive-monitor signal bundle.
// master: the link/receiver side that reports frames and clears counters.
// slave : the monitor that reports link health and error counts.
interface tm_sr_rx_mon_if;
  logic       sr_rx_done;
  logic       sr_crc_ok;
  logic       tm_rx_done;
  logic       tm_crc_ok;
  logic       cnt_clr;
  logic       sr_repeat_req;
  logic       sr_early;
  logic       sr_link_ok;
  logic       tm_link_ok;
  logic       tm_missing;
  logic [7:0] sr_err_cnt;
  logic [7:0] tm_err_cnt;

  modport master (
    output sr_rx_done, sr_crc_ok, tm_rx_done, tm_crc_ok, cnt_clr,
    input  sr_repeat_req, sr_early, sr_link_ok, tm_link_ok, tm_missing,
           sr_err_cnt, tm_err_cnt
  );

  modport slave (
    input  sr_rx_done, sr_crc_ok, tm_rx_done, tm_crc_ok, cnt_clr,
    output sr_repeat_req, sr_early, sr_link_ok, tm_link_ok, tm_missing,
           sr_err_cnt, tm_err_cnt
  );
endinterface

// File: rtl/tm_sr_rx_mon.sv
// SR/TM link monitor: watches SR frame timing with a bounded repeat-request
// retry scheme, watches TM frame arrival against a window, and keeps
// saturating error counters. All outputs are registered.
module tm_sr_rx_mon #(
  parameter int unsigned SR_PERIOD    = 5000000,
  parameter int unsigned SR_TOL       = 50000,
  parameter int unsigned SR_REPEAT_TO = 100000,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned TM_PERIOD    = 50000000,
  parameter int unsigned TM_TOL       = 500000
) (
  input  logic          clk,
  input  logic          n_rst,
  tm_sr_rx_mon_if.slave bus
);

  localparam int unsigned RW       = $clog2(MAX_RETRY + 2);
  localparam logic [23:0] SR_EARLY = 24'(SR_PERIOD - SR_TOL);
  localparam logic [23:0] SR_LATE  = 24'(SR_PERIOD + SR_TOL);
  localparam logic [23:0] SR_RTO   = 24'(SR_REPEAT_TO);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [26:0] TM_LIM   = 27'(TM_PERIOD + TM_TOL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_REPEAT,
    S_FAIL
  } sr_state_t;

  sr_state_t       state_q, state_d;
  logic [23:0]     sr_tmr_q, sr_tmr_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            sr_link_q, sr_link_d;
  logic            sr_req_q, sr_req_d;
  logic            sr_early_q, sr_early_d;
  logic [7:0]      sr_err_q, sr_err_d;

  logic            tm_on_q, tm_on_d;
  logic [26:0]     tm_tmr_q, tm_tmr_d;
  logic            tm_link_q, tm_link_d;
  logic            tm_miss_q, tm_miss_d;
  logic [7:0]      tm_err_q, tm_err_d;

  logic            sr_good, sr_bad, sr_active, sr_fault;
  logic            tm_good, tm_bad;

  function automatic logic [7:0] sat_add(input logic [7:0] v, input logic [1:0] n);
    logic [8:0] s;
    s = {1'b0, v} + {7'd0, n};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  assign sr_good   = bus.sr_rx_done & bus.sr_crc_ok;
  assign sr_bad    = bus.sr_rx_done & ~bus.sr_crc_ok;
  assign sr_active = (state_q == S_RUN) || (state_q == S_REPEAT);
  assign sr_fault  = (sr_bad & sr_active)
                   | ((state_q == S_RUN)    && (sr_tmr_q == SR_LATE))
                   | ((state_q == S_REPEAT) && (sr_tmr_q == SR_RTO));
  assign tm_good   = bus.tm_rx_done & bus.tm_crc_ok;
  assign tm_bad    = bus.tm_rx_done & ~bus.tm_crc_ok;

  // SR state, timer, retry count, flags and error counter registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      sr_tmr_q   <= '0;
      retry_q    <= '0;
      sr_link_q  <= 1'b0;
      sr_req_q   <= 1'b0;
      sr_early_q <= 1'b0;
      sr_err_q   <= '0;
    end else begin
      state_q    <= state_d;
      sr_tmr_q   <= sr_tmr_d;
      retry_q    <= retry_d;
      sr_link_q  <= sr_link_d;
      sr_req_q   <= sr_req_d;
      sr_early_q <= sr_early_d;
      sr_err_q   <= sr_err_d;
    end
  end

  // SR next-state: a good frame always wins; faults retry until exhausted
  always_comb begin
    logic [1:0] inc;
    logic       fail_evt;
    state_d    = state_q;
    sr_tmr_d   = '0;
    retry_d    = retry_q;
    sr_link_d  = sr_link_q;
    sr_req_d   = 1'b0;
    sr_early_d = 1'b0;
    fail_evt   = 1'b0;
    if (sr_active) begin
      sr_tmr_d = (sr_tmr_q == '1) ? sr_tmr_q : sr_tmr_q + 24'd1;
    end
    if (sr_good) begin
      sr_early_d = (state_q == S_RUN) && (sr_tmr_q < SR_EARLY);
      state_d    = S_RUN;
      sr_tmr_d   = '0;
      retry_d    = '0;
      sr_link_d  = 1'b1;
    end else if (sr_fault) begin
      sr_tmr_d = '0;
      if (retry_q < RETRY_MAX) begin
        state_d  = S_REPEAT;
        retry_d  = retry_q + RW'(1);
        sr_req_d = 1'b1;
      end else begin
        state_d   = S_FAIL;
        sr_link_d = 1'b0;
        fail_evt  = 1'b1;
      end
    end
    // A bad frame that also exhausts the retries counts as two errors.
    inc      = {1'b0, sr_bad} + {1'b0, fail_evt};
    sr_err_d = bus.cnt_clr ? '0 : sat_add(sr_err_q, inc);
  end

  // TM timer, flags and error counter registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tm_on_q   <= 1'b0;
      tm_tmr_q  <= '0;
      tm_link_q <= 1'b0;
      tm_miss_q <= 1'b0;
      tm_err_q  <= '0;
    end else begin
      tm_on_q   <= tm_on_d;
      tm_tmr_q  <= tm_tmr_d;
      tm_link_q <= tm_link_d;
      tm_miss_q <= tm_miss_d;
      tm_err_q  <= tm_err_d;
    end
  end

  // TM next-state: window restarts on each good frame and after each miss
  always_comb begin
    logic [1:0] inc;
    tm_on_d   = tm_on_q;
    tm_tmr_d  = tm_tmr_q;
    tm_link_d = tm_link_q;
    tm_miss_d = 1'b0;
    inc       = {1'b0, tm_bad};
    if (tm_good) begin
      tm_on_d   = 1'b1;
      tm_tmr_d  = '0;
      tm_link_d = 1'b1;
    end else if (tm_on_q) begin
      if (tm_tmr_q == TM_LIM) begin
        tm_tmr_d  = '0;
        tm_miss_d = 1'b1;
        tm_link_d = 1'b0;
        inc       = inc + 2'd1;
      end else begin
        tm_tmr_d = tm_tmr_q + 27'd1;
      end
    end
    tm_err_d = bus.cnt_clr ? '0 : sat_add(tm_err_q, inc);
  end

  assign bus.sr_repeat_req = sr_req_q;
  assign bus.sr_early      = sr_early_q;
  assign bus.sr_link_ok    = sr_link_q;
  assign bus.tm_link_ok    = tm_link_q;
  assign bus.tm_missing    = tm_miss_q;
  assign bus.sr_err_cnt    = sr_err_q;
  assign bus.tm_err_cnt    = tm_err_q;

endmodule

// File: doc/tm_sr_rx_mon.md
TM_SR_RX_MON -- requirements
Module: tm_sr_rx_mon

Interface
REQ-001 Parameters SHALL be, one per line:
- SR_PERIOD, 5000000, nominal cycles between SR frames.
- SR_TOL, 50000, tolerance in cycles.
- SR_REPEAT_TO, 100000, cycles to wait for a repeated SR.
- MAX_RETRY, 3, repeat requests allowed per SR slot.
- TM_PERIOD, 50000000, nominal cycles between TM frames.
- TM_TOL, 500000, TM tolerance in cycles.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  clock; all logic on the rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- sr_rx_done  in  1  one-cycle pulse: SR frame fully received.
- sr_crc_ok  in  1  SR CRC result; valid only with sr_rx_done.
- tm_rx_done  in  1  one-cycle pulse: TM frame fully received.
- tm_crc_ok  in  1  TM CRC result; valid only with tm_rx_done.
- cnt_clr  in  1  one-cycle pulse: clear error counters.
- sr_repeat_req  out  1  one-cycle pulse: request SR retransmission.
- sr_early  out  1  one-cycle pulse: good SR arrived below SR_PERIOD-SR_TOL.
- sr_link_ok  out  1  level: SR stream healthy.
- tm_link_ok  out  1  level: TM stream healthy.
- tm_missing  out  1  one-cycle pulse: TM window expired.
- sr_err_cnt  out  8  saturating SR error count.
- tm_err_cnt  out  8  saturating TM error count.

Function
REQ-003 Good SR SHALL mean sr_rx_done=1 and sr_crc_ok=1; bad SR SHALL mean sr_rx_done=1 and sr_crc_ok=0.
REQ-004 SR FSM states SHALL be IDLE, RUN, REPEAT and FAIL.
REQ-005 sr_tmr SHALL be 24 bits, SHALL count +1 per cycle in RUN and REPEAT, SHALL hold at 0 in IDLE and FAIL, and SHALL saturate at all-ones.
REQ-006 A good SR in any state SHALL do all of the following on the next edge:
- state becomes RUN;
- sr_tmr becomes 0;
- retry count becomes 0;
- sr_link_ok becomes 1.
REQ-007 A good SR received in RUN with sr_tmr < SR_PERIOD-SR_TOL SHALL pulse sr_early one cycle later and SHALL still be accepted.
REQ-008 A fault SHALL be any of:
- a bad SR in RUN or REPEAT;
- sr_tmr == SR_PERIOD+SR_TOL in RUN;
- sr_tmr == SR_REPEAT_TO in REPEAT.
REQ-009 On a fault with retry count < MAX_RETRY, the block SHALL, at the next edge:
- pulse sr_repeat_req for exactly one cycle;
- increment the retry count;
- clear sr_tmr;
- enter REPEAT.
REQ-010 On a fault with retry count == MAX_RETRY, the block SHALL:
- enter FAIL;
- clear sr_link_ok;
- increment sr_err_cnt once.
sr_repeat_req SHALL NOT pulse in this case.
REQ-011 A bad SR in IDLE or FAIL SHALL increment sr_err_cnt and SHALL NOT change state.
REQ-012 If a good SR and a timeout coincide, the good SR SHALL win and no repeat SHALL be issued.
REQ-013 Every bad SR SHALL also increment sr_err_cnt, in addition to any repeat it causes.
REQ-014 tm_tmr SHALL be 27 bits, SHALL start counting at the first good TM, and SHALL clear on each good TM.
REQ-015 A good TM SHALL set tm_link_ok to 1.
REQ-016 When tm_tmr == TM_PERIOD+TM_TOL, the block SHALL:
- pulse tm_missing for one cycle;
- clear tm_link_ok;
- increment tm_err_cnt;
- clear tm_tmr and continue counting, so repeated misses pulse every TM_PERIOD+TM_TOL+1 cycles.
REQ-017 A bad TM SHALL increment tm_err_cnt and SHALL leave tm_link_ok and tm_tmr unchanged.
REQ-018 Error counters SHALL saturate at 255, never wrapping.
REQ-019 cnt_clr SHALL zero both counters, and SHALL override a simultaneous increment.
REQ-020 All outputs SHALL be registered, with one-cycle latency from the causing input or timer value.

Reset
REQ-021 While n_rst=0, the block SHALL hold:
- SR FSM in IDLE, with sr_tmr, tm_tmr and retry count at 0;
- tm timer not started;
- all pulse outputs 0;
- sr_link_ok and tm_link_ok at 0;
- both counters at 0.
REQ-022 Reset asserted mid-operation SHALL abort any REPEAT immediately; no sr_repeat_req SHALL appear after reset is released until a new fault occurs.

Verification
Bench parameters: SR_PERIOD=100, SR_TOL=10, SR_REPEAT_TO=20, MAX_RETRY=2, TM_PERIOD=1000, TM_TOL=10.
REQ-023 Good SR every 100 cycles, 20 frames -> sr_link_ok=1 from the first frame+1; no sr_repeat_req, no sr_early; sr_err_cnt=0.
REQ-024 Good SR, then silence -> sr_repeat_req at 111 cycles after the frame, then at +21 cycles; then FAIL; sr_link_ok=0; sr_err_cnt=1; exactly 2 pulses.
REQ-025 Bad SR in RUN -> sr_repeat_req one cycle later, sr_err_cnt=1; good SR 5 cycles later -> RUN, retry count 0, sr_link_ok=1.
REQ-026 Good SR at sr_tmr=50 -> sr_early pulse; frame accepted; sr_tmr restarts at 0.
REQ-027 Good TM, then none -> tm_missing at 1011 and 2022 cycles; tm_err_cnt=2; tm_link_ok=0; 300 bad TMs -> tm_err_cnt=255; cnt_clr -> 0.
REQ-028 n_rst pulsed while in REPEAT -> all outputs 0 at once; IDLE; no sr_repeat_req within 500 cycles of silence.
